// File: rtl/calc_entry_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : calc_entry_fsm
//  Brief    : Keypad-to-ALU entry sequencer; builds operand A, operator and
//             operand B from decoded key codes and strobes calc_valid on '='.
//  Revision : 1.0  initial release
// ============================================================================
module calc_entry_fsm #(
    parameter int DATA_W     = 20,
    parameter int MAX_DIGITS = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_valid,
    input  logic [4:0]        key_code,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [4:0]        operador,
    output logic              calc_valid,
    output logic [DATA_W-1:0] entry_value,
    output logic [2:0]        entry_digits,
    output logic [1:0]        state_o
);

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_OP   = 2'd1,
        S_B    = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [4:0] c_KEY_EQ  = 5'd14;
    localparam logic [4:0] c_KEY_CLR = 5'd15;
    localparam logic [2:0] c_MAX_DIG = 3'(MAX_DIGITS);

    state_t            r_state,  w_state_nx;
    logic [DATA_W-1:0] r_op_a,   w_op_a_nx;
    logic [DATA_W-1:0] r_op_b,   w_op_b_nx;
    logic [4:0]        r_oper,   w_oper_nx;
    logic [2:0]        r_digits, w_digits_nx;
    logic              r_calc_valid, w_calc_valid_nx;

    logic              w_is_digit;
    logic              w_is_oper;
    logic [DATA_W-1:0] w_digit;
    logic              w_room;

    assign w_is_digit = (key_code < 5'd10);
    assign w_is_oper  = (key_code >= 5'd10) && (key_code <= 5'd13);
    assign w_digit    = DATA_W'(key_code[3:0]);
    assign w_room     = (r_digits < c_MAX_DIG);

    // operand*10 + d as shifts; DATA_W is sized to hold the largest operand
    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] v,
                                                   input logic [DATA_W-1:0] d);
        return (v << 3) + (v << 1) + d;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_A;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_oper       <= '0;
            r_digits     <= '0;
            r_calc_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_op_a       <= w_op_a_nx;
            r_op_b       <= w_op_b_nx;
            r_oper       <= w_oper_nx;
            r_digits     <= w_digits_nx;
            r_calc_valid <= w_calc_valid_nx;
        end
    end

    always_comb begin
        w_state_nx      = r_state;
        w_op_a_nx       = r_op_a;
        w_op_b_nx       = r_op_b;
        w_oper_nx       = r_oper;
        w_digits_nx     = r_digits;
        w_calc_valid_nx = 1'b0;

        if (key_valid) begin
            if (w_is_digit) begin
                case (r_state)
                    S_A: begin
                        if (w_room) begin
                            w_op_a_nx   = shift_in(r_op_a, w_digit);
                            w_digits_nx = r_digits + 3'd1;
                        end
                    end
                    S_OP: begin
                        w_op_b_nx   = w_digit;
                        w_digits_nx = 3'd1;
                        w_state_nx  = S_B;
                    end
                    S_B: begin
                        if (w_room) begin
                            w_op_b_nx   = shift_in(r_op_b, w_digit);
                            w_digits_nx = r_digits + 3'd1;
                        end
                    end
                    default: begin
                        // a digit after a result starts a fresh expression
                        w_op_a_nx   = w_digit;
                        w_op_b_nx   = '0;
                        w_oper_nx   = '0;
                        w_digits_nx = 3'd1;
                        w_state_nx  = S_A;
                    end
                endcase
            end else if (w_is_oper) begin
                if (r_state == S_A || r_state == S_OP) begin
                    w_oper_nx  = key_code;
                    w_state_nx = S_OP;
                end
            end else if (key_code == c_KEY_EQ) begin
                if (r_state == S_B) begin
                    w_state_nx      = S_DONE;
                    w_calc_valid_nx = 1'b1;
                end
            end else if (key_code == c_KEY_CLR) begin
                w_op_a_nx   = '0;
                w_op_b_nx   = '0;
                w_oper_nx   = '0;
                w_digits_nx = '0;
                w_state_nx  = S_A;
            end
        end
    end

    assign op_a         = r_op_a;
    assign op_b         = r_op_b;
    assign operador     = r_oper;
    assign calc_valid   = r_calc_valid;
    assign entry_value  = (r_state == S_A || r_state == S_OP) ? r_op_a : r_op_b;
    assign entry_digits = r_digits;
    assign state_o      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_calc_entry_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_calc_entry_fsm
//  Brief    : Scoreboard bench for calc_entry_fsm with directed key sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_calc_entry_fsm;

    localparam int DATA_W = 20;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              key_valid = 1'b0;
    logic [4:0]        key_code = '0;
    logic [DATA_W-1:0] op_a, op_b, entry_value;
    logic [4:0]        operador;
    logic              calc_valid;
    logic [2:0]        entry_digits;
    logic [1:0]        state_o;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [4:0]        op;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    calc_entry_fsm #(.DATA_W(DATA_W), .MAX_DIGITS(6)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .op_a(op_a), .op_b(op_b), .operador(operador), .calc_valid(calc_valid),
        .entry_value(entry_value), .entry_digits(entry_digits), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // monitor: every calc_valid strobe must match the oldest queued expression
    always @(negedge clk) begin
        if (!rst && calc_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL calc_valid_unexpected: got a=%0d b=%0d op=%0d, expected no strobe",
                         op_a, op_b, operador);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (op_a !== e.a || op_b !== e.b || operador !== e.op) begin
                    n_bad++;
                    $display("FAIL calc_result: got a=%0d b=%0d op=%0d, expected a=%0d b=%0d op=%0d",
                             op_a, op_b, operador, e.a, e.b, e.op);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic press(input logic [4:0] c);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = c;
    endtask

    task automatic idle();
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = '0;
    endtask

    task automatic push(input int a, input int b, input int op);
        exp_t e;
        e.a  = DATA_W'(a);
        e.b  = DATA_W'(b);
        e.op = 5'(op);
        exp_q.push_back(e);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_op_a"},       32'(op_a), 0);
        chk({tag, "_op_b"},       32'(op_b), 0);
        chk({tag, "_operador"},   32'(operador), 0);
        chk({tag, "_calc_valid"}, 32'(calc_valid), 0);
        chk({tag, "_entry"},      32'(entry_value), 0);
        chk({tag, "_digits"},     32'(entry_digits), 0);
        chk({tag, "_state"},      32'(state_o), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_reset_values("reset");

        // 1: 12 + 3 =
        push(12, 3, 10);
        press(1); press(2); press(10); press(3); press(14); idle();
        chk("t1_state", 32'(state_o), 3);
        chk("t1_entry_b", 32'(entry_value), 3);
        idle();
        chk("t1_valid_drop", 32'(calc_valid), 0);

        // 2: seventh digit dropped
        press(15);
        for (int i = 1; i <= 7; i++) press(5'(i));
        idle();
        chk("t2_op_a", 32'(op_a), 123456);
        chk("t2_digits", 32'(entry_digits), 6);
        chk("t2_entry", 32'(entry_value), 123456);

        // 3: operator replaced, extra '=' ignored
        press(15);
        push(9, 4, 11);
        press(9); press(10); press(11); press(4); press(14); press(14); idle();
        chk("t3_operador", 32'(operador), 11);
        chk("t3_state", 32'(state_o), 3);

        // 4: '=' with empty B ignored, then B=0 allowed
        press(15);
        press(5); press(12); press(14); idle();
        chk("t4_state_op", 32'(state_o), 1);
        chk("t4_entry_a", 32'(entry_value), 5);
        push(5, 0, 12);
        press(0); press(14); idle();

        // 5: clear mid-B, then a new expression
        press(15);
        press(7); press(13); press(8); press(15); idle();
        chk_reset_values("t5_clear");
        push(2, 2, 10);
        press(2); press(10); press(2); press(14); idle();

        // digit after result restarts entry
        press(4); idle();
        chk("t7_op_a", 32'(op_a), 4);
        chk("t7_op_b", 32'(op_b), 0);
        chk("t7_operador", 32'(operador), 0);
        chk("t7_state", 32'(state_o), 0);

        // 6: rst with '=' in S_B wins
        press(15);
        press(1); press(10); press(3); idle();
        chk("t6_state_b", 32'(state_o), 2);
        @(negedge clk);
        rst = 1'b1; key_valid = 1'b1; key_code = 5'd14;
        @(negedge clk);
        rst = 1'b0; key_valid = 1'b0; key_code = '0;
        chk_reset_values("t6_rst");
        idle();
        chk("t6_no_valid", 32'(calc_valid), 0);

        repeat (3) idle();
        chk("pending_expected", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
